// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access sizes, FSM states and the
// wait-state counter width.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam int         WS_CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;
endpackage

// File: rtl/mem_stage_ws_if.sv
// Request/response bundle between the pipeline (master) and the memory stage (slave).
interface mem_stage_ws_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] alu_result;
    logic [31:0] ST_value;
    logic [31:0] memory_result;
    logic        stall;
    logic        addr_err;

    modport master (
        output mem_r_en, mem_w_en, size, sign_ext, alu_result, ST_value,
        input  memory_result, stall, addr_err
    );
    modport slave (
        input  mem_r_en, mem_w_en, size, sign_ext, alu_result, ST_value,
        output memory_result, stall, addr_err
    );
endinterface

// File: rtl/mem_addr_map.sv
// Byte address to word index / lane / byte-enable decode, with range and
// alignment checking.
module mem_addr_map
    import mem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic [31:0]              alu_result,
    input  logic [1:0]               size,
    output logic [$clog2(DEPTH)-1:0] index,
    output logic [1:0]               lane,
    output logic [3:0]               be,
    output logic                     addr_err
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0] off;
    logic        oor;
    logic        misal;

    // Unsigned offset: addresses below the base wrap high and fail the range test.
    always_comb begin
        off   = alu_result - BASE_ADDR;
        oor   = off >= 32'(4 * DEPTH);
        index = off[IDX_W+1:2];
        lane  = off[1:0];
        be    = '0;
        misal = 1'b0;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: begin
                be    = 4'b0011 << lane;
                misal = lane[0];
            end
            SZ_WORD: begin
                be    = 4'b1111;
                misal = lane != 2'd0;
            end
            default: misal = 1'b1;
        endcase
        addr_err = oor | misal;
    end
endmodule

// File: rtl/mem_stage_ws.sv
// Memory stage with a word-wide data array, configurable wait states and a
// stall handshake; byte/half/word loads and stores with load extension.
module mem_stage_ws
    import mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic           clock,
    input  logic           reset,
    mem_stage_ws_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WS_CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? WS_CNT_W'(WAIT_STATES - 1) : '0;

    logic [IDX_W-1:0] index;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic             map_err;

    mem_addr_map #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_map (
        .alu_result (bus.alu_result),
        .size       (bus.size),
        .index      (index),
        .lane       (lane),
        .be         (be),
        .addr_err   (map_err)
    );

    state_e                  state_q, state_d;
    logic [WS_CNT_W-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0][31:0]  mem_q, mem_d;

    logic        req, legal, done, stall_c;
    logic [31:0] wdata, rword, rshift, ld;

    always_comb begin
        req     = bus.mem_r_en | bus.mem_w_en;
        legal   = req & ~map_err;
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    if (WAIT_STATES == 0) begin
                        done = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            default: begin
                // A dropped request during the wait is a flush: abort without writing.
                if (!legal) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        case (bus.size)
            SZ_BYTE: wdata = {4{bus.ST_value[7:0]}};
            SZ_HALF: wdata = {2{bus.ST_value[15:0]}};
            default: wdata = bus.ST_value;
        endcase
        mem_d = mem_q;
        if (done && bus.mem_w_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_d[index][8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rword  = mem_q[index];
        rshift = rword >> {lane, 3'b000};
        case (bus.size)
            SZ_BYTE: ld = {{24{bus.sign_ext & rshift[7]}}, rshift[7:0]};
            SZ_HALF: ld = {{16{bus.sign_ext & rshift[15]}}, rshift[15:0]};
            default: ld = rword;
        endcase
    end

    // Outputs are forced quiet while reset is held, even with a request pending.
    assign bus.stall         = stall_c & reset;
    assign bus.addr_err      = req & map_err & reset;
    assign bus.memory_result = (reset && done && bus.mem_r_en && !bus.mem_w_en) ? ld : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
Parametrised memory stage of the 5-stage core: maps the ALU address onto an internal data memory and performs loads and stores. Supports byte, halfword and word accesses with sign or zero extension. Has configurable wait states and holds the pipeline with a stall output until each access completes. Flags misaligned and out-of-range addresses instead of corrupting memory.

Parameters:
DEPTH, 64, number of 32-bit words in the data memory (power of two, ≥4)
BASE_ADDR, 1024, byte address mapped to word 0
WAIT_STATES, 0, extra cycles per legal access (0..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_r_en  in  1  load request
mem_w_en  in  1  store request
size  in  2  access size: 0 byte, 1 half, 2 word; 3 reserved
sign_ext  in  1  load extension: 1 sign-extend, 0 zero-extend
alu_result  in  32  byte address
ST_value  in  32  store data, right-aligned (low bits used for byte/half)
memory_result  out  32  extended load data, valid in the completion cycle
stall  out  1  pipeline hold; the request must stay stable while this is high
addr_err  out  1  illegal access in this cycle (combinational)

Behaviour:
- Address map: off = alu_result − BASE_ADDR, taken as a 32-bit unsigned value. Word index = off[log2(DEPTH)+1:2]; lane = off[1:0].
- Illegal access (addr_err=1):
  - off ≥ 4·DEPTH, which includes addresses below BASE_ADDR through unsigned wrap;
  - a half access with lane[0]=1;
  - a word access with lane≠0;
  - size=3.
- An illegal access completes immediately: stall=0, no write, memory_result=0, FSM unaffected.
- req = mem_r_en | mem_w_en. If both are set, the access is a store and memory_result=0.
- FSM states are IDLE and WAIT, with a 4-bit counter cnt.
  - IDLE, legal req, WAIT_STATES=0: completes this cycle, stall=0, stays in IDLE.
  - IDLE, legal req, WAIT_STATES>0: stall=1, cnt<=WAIT_STATES−1, go to WAIT.
  - WAIT, req held, cnt≠0: stall=1, cnt<=cnt−1.
  - WAIT, req held, cnt=0: completion cycle, stall=0, go to IDLE.
  - WAIT, req dropped (flush): abort; no write, stall=0, go to IDLE.
- A legal access therefore occupies exactly WAIT_STATES+1 cycles, of which stall is high for WAIT_STATES.
- Store: commits at the rising edge that ends the completion cycle, using byte enables.
  - byte: lane only, data ST_value[7:0];
  - half: lanes {lane+1, lane}, data ST_value[15:0];
  - word: all four lanes.
- Load: memory_result is combinational from the array in the completion cycle.
  - The selected byte or half is shifted to bit 0 and extended per sign_ext.
  - memory_result=0 in every other cycle.
- Read-after-write: a load completing in the cycle right after a store's completion sees the new data.
- Reset (reset=0, any time, including mid-WAIT):
  - FSM to IDLE, cnt=0, all memory words to 0;
  - stall=0, addr_err=0, memory_result=0;
  - an in-flight store is discarded.

Decomposition:
- Shared package/defines mem_pkg:
  - SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - state encoding ST_IDLE, ST_WAIT;
  - WS_CNT_W=4.
- Sub-module mem_addr_map (combinational, parametrised by DEPTH and BASE_ADDR): inputs alu_result and size; outputs index, lane, byte-enable mask and addr_err.
- FSM, array and load extension stay in mem_stage_ws.

Test Plan:
1. WAIT_STATES=2: word store 0xDEADBEEF at 1028 → stall high 2 cycles, then low; following word load at 1028 → stall 2 cycles, memory_result=0xDEADBEEF in the completion cycle only.
2. Byte store 0xAA at 1029, then loads at 1029: signed byte → 0xFFFFFFAA; unsigned byte → 0x000000AA; word load at 1028 → 0xDEADAAEF.
3. Half store 0x8001 at 1030, then signed half load at 1030 → 0xFFFF8001; half load at 1027 → addr_err=1, stall=0, memory_result=0, memory unchanged.
4. Out-of-range: load at 1280 and store at 1020 (DEPTH=64) → addr_err=1, no stall, memory contents unchanged.
5. Abort and reset: deassert a store during WAIT → no write, stall=0 next cycle; assert reset=0 mid-WAIT → stall=0 immediately, all words read 0 afterwards.
6. WAIT_STATES=0: back-to-back word store 0x12345678 at 1032, then load at 1032 → never stalls; load returns 0x12345678 the cycle after the store.
